instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 15, max wait cycles for imem_ack before error (range 1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_addr  output  32  byte address of the requested instruction; equals pc_out.
REQ-007 imem_ack  input  1  memory returns valid imem_rdata this cycle.
REQ-008 imem_rdata  input  32  instruction word.
REQ-009 stall  input  1  downstream decode/control not ready; hold current instruction.
REQ-010 jump  input  1  Jump from control unit for the issued instruction.
REQ-011 branch_taken  input  1  Branch qualified by comparison result.
REQ-012 jr_control  input  1  register-indirect jump.
REQ-013 jr_target  input  32  register value for jr.
REQ-014 instr  output  32  latched instruction register.
REQ-015 opcode  output  6  instr[31:26], drives the control unit opcode input.
REQ-016 pc_out  output  32  address of the current fetch/instruction.
REQ-017 pc_plus4  output  32  pc_out + 4 (mod 2^32), used for link writes.
REQ-018 instr_valid  output  1  instr/opcode are valid for decode.
REQ-019 fetch_err  output  1  sticky fetch timeout flag.

Function
REQ-020 FSM states: RST_WAIT, REQ, ISSUE, ERR; encoding is free.
REQ-021 RST_WAIT: outputs idle for one cycle after reset release, then REQ unconditionally.
REQ-022 REQ: imem_req=1, imem_addr=pc_out, held stable until the ack cycle; wait counter increments each cycle without ack.
REQ-023 REQ with imem_ack=1: instr <= imem_rdata, counter cleared, next state ISSUE; imem_req deasserts the cycle after ack.
REQ-024 REQ, counter reaches TIMEOUT with no ack: ERR; ack in the same cycle the counter expires wins (ISSUE, no error).
REQ-025 ISSUE: instr_valid=1, imem_req=0; with stall=1, instr, pc_out and state hold.
REQ-026 ISSUE with stall=0: pc_out <= next_pc, state REQ; instr_valid low from the next cycle; one fetch per instruction, minimum 2 cycles per instruction with zero-wait memory.
REQ-027 next_pc priority, sampled in the ISSUE cycle with stall=0: jr_control -> jr_target; else jump -> {pc_plus4[31:28], instr[25:0], 2'b00}; else branch_taken -> pc_plus4 + (sign-extended instr[15:0] << 2); else pc_plus4.
REQ-028 All address arithmetic is 32-bit, wrapping modulo 2^32 with no overflow flag; 32'hFFFF_FFFC + 4 = 0.
REQ-029 jump/branch_taken/jr_control/jr_target are ignored outside ISSUE and while stall=1.
REQ-030 imem_ack outside REQ is ignored; instr is unchanged.
REQ-031 ERR: fetch_err=1, imem_req=0, instr_valid=0, pc_out frozen; exit only by reset.
REQ-032 opcode is combinational from instr, with no extra latency.

Reset
REQ-033 rst_n low asynchronously forces: state RST_WAIT, pc_out=RESET_PC, instr=0, imem_req=0, instr_valid=0, fetch_err=0, counter=0.
REQ-034 Reset asserted mid-REQ drops imem_req immediately without waiting for a clock; a late ack after release is ignored per REQ-030.

Verification
REQ-035 Reset release, zero-wait ack, rdata 32'h0000_0000, stall=0 -> fetches at 0,4,8; instr_valid pulses every 2nd cycle; opcode=0.
REQ-036 Issue at pc 32'h1000 with rdata 32'h0400_0010 and jump=1 -> next imem_addr=32'h0000_0040; with jr_control=1 and jr_target=32'h2000 also set -> 32'h2000.
REQ-037 pc 32'h100, instr[15:0]=16'hFFFE, branch_taken=1 -> next address 32'h0FC; with branch_taken=0 -> 32'h104.
REQ-038 stall held high 5 cycles in ISSUE with redirect inputs toggling -> instr and pc stable; after stall drops, only that cycle's inputs apply.
REQ-039 No ack for TIMEOUT=15 cycles -> fetch_err=1, imem_req=0 permanently; ack exactly at expiry -> no error and the instruction is issued.
REQ-040 rst_n low during REQ -> imem_req=0 asynchronously; after release, RESET_PC is fetched again.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch unit with PC redirect.
// Ports:
//   clk, rst_n                : clock, async active-low reset
//   imem_req/addr/ack/rdata   : instruction memory read handshake
//   stall                     : hold the issued instruction
//   jump, branch_taken,
//   jr_control, jr_target     : redirect controls sampled when leaving ISSUE
//   instr, opcode, instr_valid: issued instruction to decode
//   pc_out, pc_plus4          : current PC and its fall-through address
//   fetch_err                 : sticky memory timeout flag
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          TIMEOUT  = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        jump,
   input  logic        branch_taken,
   input  logic        jr_control,
   input  logic [31:0] jr_target,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   output logic        instr_valid,
   output logic        fetch_err
);

   typedef enum logic [1:0] {
      RST_WAIT,
      REQ,
      ISSUE,
      ERR
   } state_t;

   // Last wait count that may still be rescued by an ack.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state;
   logic [7:0]  wait_cnt;
   logic [31:0] pc;
   logic [31:0] next_pc;
   logic [31:0] br_off;

   assign pc_out    = pc;
   assign imem_addr = pc;
   assign pc_plus4  = pc + 32'd4;
   assign opcode    = instr[31:26];
   assign br_off    = {{14{instr[15]}}, instr[15:0], 2'b00};

   always_comb begin
      next_pc = pc_plus4;
      if (jr_control)
         next_pc = jr_target;
      else if (jump)
         next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      else if (branch_taken)
         next_pc = pc_plus4 + br_off;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RST_WAIT;
         pc          <= RESET_PC;
         instr       <= 32'h0;
         wait_cnt    <= 8'h0;
         imem_req    <= 1'b0;
         instr_valid <= 1'b0;
         fetch_err   <= 1'b0;
      end else begin
         unique case (state)
            RST_WAIT: begin
               state    <= REQ;
               imem_req <= 1'b1;
            end
            REQ: begin
               // An ack in the expiring cycle still wins.
               if (imem_ack) begin
                  instr       <= imem_rdata;
                  wait_cnt    <= 8'h0;
                  state       <= ISSUE;
                  imem_req    <= 1'b0;
                  instr_valid <= 1'b1;
               end else if (wait_cnt == CNT_LAST) begin
                  state     <= ERR;
                  imem_req  <= 1'b0;
                  fetch_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            ISSUE: begin
               if (!stall) begin
                  pc          <= next_pc;
                  state       <= REQ;
                  imem_req    <= 1'b1;
                  instr_valid <= 1'b0;
               end
            end
            ERR: begin
               fetch_err <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized scoreboard bench for instr_fetch.
// The bench plays instruction memory and predicts the PC stream.
module tb_instr_fetch;

   localparam logic [31:0] RPC = 32'h0000_0000;
   localparam int          TO  = 15;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        stall = 1'b0;
   logic        jump = 1'b0;
   logic        branch_taken = 1'b0;
   logic        jr_control = 1'b0;
   logic [31:0] jr_target = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;
   logic        instr_valid;
   logic        fetch_err;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] aq[$];
   logic [63:0] iq[$];
   logic [31:0] mpc;
   logic [63:0] cur = 64'h0;
   logic        prev_req = 1'b0;
   logic        prev_valid = 1'b0;

   instr_fetch #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .stall(stall), .jump(jump), .branch_taken(branch_taken),
      .jr_control(jr_control), .jr_target(jr_target),
      .instr(instr), .opcode(opcode), .pc_out(pc_out),
      .pc_plus4(pc_plus4), .instr_valid(instr_valid),
      .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] model_next(
      input logic [31:0] pc, input logic [31:0] word,
      input logic jr, input logic [31:0] tgt,
      input logic jmp, input logic br);
      logic [31:0] seq;
      int          imm;
      seq = pc + 32'd4;
      imm = int'($signed(word[15:0]));
      if (jr)
         return tgt;
      if (jmp)
         return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 4);
      if (br)
         return seq + 32'(imm * 4);
      return seq;
   endfunction

   // Monitor: addresses on each new request, instructions on each issue.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_req   = 1'b0;
         prev_valid = 1'b0;
      end else begin
         if (imem_req && !prev_req) begin
            if (aq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_req actual=%h expected=none",
                        imem_addr);
            end else begin
               chk("imem_addr", imem_addr, aq.pop_front());
            end
         end
         if (imem_req)
            chk("valid_in_req", {31'h0, instr_valid}, 32'h0);
         if (instr_valid && !prev_valid) begin
            if (iq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_issue actual=%h expected=none",
                        instr);
            end else begin
               cur = iq.pop_front();
               chk("issue_pc", pc_out, cur[63:32]);
               chk("issue_instr", instr, cur[31:0]);
               chk("opcode", {26'h0, opcode}, cur[31:0] >> 26);
               chk("pc_plus4", pc_plus4, cur[63:32] + 32'd4);
            end
         end else if (instr_valid) begin
            chk("hold_instr", instr, cur[31:0]);
            chk("hold_pc", pc_out, cur[63:32]);
         end
         prev_req   = imem_req;
         prev_valid = instr_valid;
      end
   end

   task automatic wait_req();
      int n = 0;
      while (imem_req !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (imem_req !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL req_wait actual=%b expected=1", imem_req);
      end
   endtask

   task automatic do_instr(input logic [31:0] word, input int w,
                           input int s, input logic jr,
                           input logic [31:0] tgt, input logic jmp,
                           input logic br);
      wait_req();
      for (int i = 0; i < w; i++) begin
         imem_ack   = 1'b0;
         imem_rdata = $urandom;
         @(negedge clk);
      end
      imem_ack   = 1'b1;
      imem_rdata = word;
      iq.push_back({mpc, word});
      @(negedge clk);
      for (int i = 0; i < s; i++) begin
         stall        = 1'b1;
         jr_control   = 1'($urandom);
         jump         = 1'($urandom);
         branch_taken = 1'($urandom);
         jr_target    = $urandom;
         imem_ack     = 1'($urandom);
         imem_rdata   = $urandom;
         @(negedge clk);
      end
      stall        = 1'b0;
      imem_ack     = 1'b0;
      jr_control   = jr;
      jr_target    = tgt;
      jump         = jmp;
      branch_taken = br;
      mpc = model_next(mpc, word, jr, tgt, jmp, br);
      aq.push_back(mpc);
      @(negedge clk);
      jr_control   = 1'($urandom);
      jump         = 1'($urandom);
      branch_taken = 1'($urandom);
      jr_target    = $urandom;
   endtask

   task automatic reset_checks();
      chk("rst_pc", pc_out, RPC);
      chk("rst_instr", instr, 32'h0);
      chk("rst_req", {31'h0, imem_req}, 32'h0);
      chk("rst_valid", {31'h0, instr_valid}, 32'h0);
      chk("rst_err", {31'h0, fetch_err}, 32'h0);
   endtask

   initial begin
      mpc = RPC;
      repeat (2) @(negedge clk);
      reset_checks();
      aq.push_back(RPC);
      rst_n = 1'b1;
      #1;
      chk("rst_wait_idle", {31'h0, imem_req}, 32'h0);

      // Sequential zero-wait fetches.
      repeat (3) do_instr(32'h0, 0, 0, 0, 32'h0, 0, 0);
      // Jump / jr priority.
      do_instr(32'h0, 0, 0, 1, 32'h1000, 0, 0);
      do_instr(32'h0400_0010, 0, 0, 0, 32'h0, 1, 0);
      do_instr(32'h0400_0010, 1, 0, 1, 32'h2000, 1, 0);
      // Backward branch and not-taken.
      do_instr(32'h0, 0, 0, 1, 32'h100, 0, 0);
      do_instr(32'h0000_FFFE, 0, 0, 0, 32'h0, 0, 1);
      do_instr(32'h0, 0, 0, 1, 32'h100, 0, 0);
      do_instr(32'h0000_FFFE, 0, 0, 0, 32'h0, 0, 0);
      // Wrap at top of address space, with a long stall.
      do_instr(32'h0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
      do_instr(32'h0000_0003, 0, 5, 0, 32'h0, 0, 1);

      for (int k = 0; k < 40; k++)
         do_instr($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom_range(0, 5) == 0), $urandom & ~32'h3,
                  1'($urandom_range(0, 3) == 0), 1'($urandom));

      // Ack arriving in the expiring cycle is accepted.
      do_instr($urandom, TO - 1, 0, 0, 32'h0, 0, 0);

      // No ack at all: sticky error.
      wait_req();
      imem_ack = 1'b0;
      repeat (TO - 1) @(negedge clk);
      chk("pre_expiry_err", {31'h0, fetch_err}, 32'h0);
      chk("pre_expiry_req", {31'h0, imem_req}, 32'h1);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         chk("err_flag", {31'h0, fetch_err}, 32'h1);
         chk("err_req", {31'h0, imem_req}, 32'h0);
         chk("err_valid", {31'h0, instr_valid}, 32'h0);
         chk("err_pc", pc_out, mpc);
         imem_ack   = 1'($urandom);
         imem_rdata = $urandom;
         @(negedge clk);
      end

      // Recover by reset.
      imem_ack = 1'b0;
      rst_n    = 1'b0;
      #1;
      reset_checks();
      mpc = RPC;
      @(negedge clk);
      aq.push_back(RPC);
      rst_n = 1'b1;
      repeat (3)
         do_instr($urandom, $urandom_range(0, 2), 0, 0, 32'h0, 0, 0);

      // Reset in the middle of a request drops it without a clock.
      wait_req();
      imem_ack = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_req_drop", {31'h0, imem_req}, 32'h0);
      chk("async_pc", pc_out, RPC);
      mpc = RPC;
      @(negedge clk);
      aq.push_back(RPC);
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      rst_n      = 1'b1;
      do_instr(32'h1234_5678, 0, 0, 0, 32'h0, 0, 0);
      do_instr($urandom, 1, 1, 0, 32'h0, 0, 0);

      @(negedge clk);
      chk("issue_queue_drained", 32'(iq.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
